// File: rtl/sync_fifo_reader.sv
// Read-side master for sync_fifo: pops words on credit and re-presents them on a valid/ready
// stream through a 2-entry buffer. Define FIFO_READER_LAST_EN to enable burst m_last generation.
module sync_fifo_reader #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned CNT_WIDTH = 32,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    input  logic [WIDTH-1:0]     fifo_dout,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [WIDTH-1:0]     m_data,
    output logic                 m_last,
    output logic [CNT_WIDTH-1:0] word_cnt
);

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} occ_e;

    occ_e                 state_q, state_d;
    logic                 inflight_q;
    logic [WIDTH-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CNT_WIDTH-1:0] word_cnt_q;
    logic                 hs;
    logic [1:0]           occ;
    logic [1:0]           occ_pop;
    logic [2:0]           credit_sum;
    logic [2:0]           credit_lim;

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q    <= StEmpty;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= fifo_rd_en;
            head_q     <= head_d;
            tail_q     <= tail_d;
            if (hs) begin
                word_cnt_q <= word_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StEmpty: if (inflight_q) state_d = StOne;
            StOne: begin
                if (inflight_q && !hs) begin
                    state_d = StTwo;
                end else if (!inflight_q && hs) begin
                    state_d = StEmpty;
                end
            end
            StTwo:   if (hs && !inflight_q) state_d = StOne;
            default: state_d = StEmpty;
        endcase
    end

    always_comb begin
        m_valid = 1'b0;
        occ     = 2'd0;
        case (state_q)
            StOne: begin
                m_valid = 1'b1;
                occ     = 2'd1;
            end
            StTwo: begin
                m_valid = 1'b1;
                occ     = 2'd2;
            end
            default: ;
        endcase
        hs         = m_valid && m_ready;
        // credit = occ + inflight - hs < 2, rearranged to stay unsigned
        credit_sum = {1'b0, occ} + {2'b00, inflight_q};
        credit_lim = hs ? 3'd3 : 3'd2;
        fifo_rd_en = rst_n && !fifo_empty && (credit_sum < credit_lim);
    end

    // Pop first, then the arriving word lands in the first free slot.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        occ_pop = occ - {1'b0, hs};
        if (hs && state_q == StTwo) begin
            head_d = tail_q;
        end
        if (inflight_q) begin
            if (occ_pop == 2'd0) begin
                head_d = fifo_dout;
            end else begin
                tail_d = fifo_dout;
            end
        end
    end

    assign m_data   = head_q;
    assign word_cnt = word_cnt_q;

`ifdef FIFO_READER_LAST_EN
    localparam int unsigned BcW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    logic [BcW-1:0] burst_q, burst_d;
    logic           head_last_q, head_last_d, tail_last_q, tail_last_d;
    logic           arr_last;

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            burst_q     <= '0;
            head_last_q <= 1'b0;
            tail_last_q <= 1'b0;
        end else begin
            burst_q     <= burst_d;
            head_last_q <= head_last_d;
            tail_last_q <= tail_last_d;
        end
    end

    // An arriving word sits behind occ buffered words, so its burst position is burst_q + occ.
    always_comb begin
        arr_last = ((int'(burst_q) + int'(occ)) % int'(BURST_LEN)) == (int'(BURST_LEN) - 1);
        burst_d  = burst_q;
        if (hs) begin
            burst_d = (int'(burst_q) == int'(BURST_LEN) - 1) ? '0 : burst_q + BcW'(1);
        end
        head_last_d = head_last_q;
        tail_last_d = tail_last_q;
        if (hs && state_q == StTwo) begin
            head_last_d = tail_last_q;
        end
        if (inflight_q) begin
            if (occ_pop == 2'd0) begin
                head_last_d = arr_last;
            end else begin
                tail_last_d = arr_last;
            end
        end
    end

    assign m_last = m_valid && head_last_q;
`else
    logic unused_burst_len;
    assign unused_burst_len = (BURST_LEN != 0);
    assign m_last           = 1'b0;
`endif

endmodule
